// File: rtl/gsm_buf_alloc_pkg.sv
// rtl/gsm_buf_alloc_pkg.sv - shared types and sizing helpers for the GSM buffer allocator
package gsm_buf_alloc_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   // Ceiling log2, never less than 1 so a 1-way counter still gets a bit.
   function automatic int clogb(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/gsm_rr_arb.sv
// rtl/gsm_rr_arb.sv - NUM_IN-way round-robin arbiter; pointer moves past the winner on grant
module gsm_rr_arb
   import gsm_buf_alloc_pkg::*;
#(
   parameter int NUM_IN = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [NUM_IN-1:0] req,
   input  logic              en,
   output logic [NUM_IN-1:0] gnt
);

   localparam int PW = clogb(NUM_IN);

   logic [PW-1:0] ptr, ptr_nxt, idx;

   // Scan from the farthest slot back to the pointer so the nearest requester wins.
   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      idx     = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_IN);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            ptr_nxt  = (idx == PW'(NUM_IN - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) ptr <= '0;
      else if (en && (|req)) ptr <= ptr_nxt;
   end

endmodule

// File: rtl/gsm_sdp_ram.sv
// rtl/gsm_sdp_ram.sv - inferred simple dual-port RAM, registered read, read-old-data on collision
module gsm_sdp_ram #(
   parameter int AW = 9,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/gsm_buf_alloc.sv
// rtl/gsm_buf_alloc.sv - free-cell allocator and round-robin ingress arbiter for one GSM bank
module gsm_buf_alloc
   import gsm_buf_alloc_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int AWIDTH = 9,
   parameter int LOW_WM = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [NUM_IN-1:0] i_req,
   output logic [NUM_IN-1:0] o_gnt,
   output logic [AWIDTH-1:0] o_gnt_addr,
   input  logic              i_free,
   input  logic [AWIDTH-1:0] i_free_addr,
   output logic              o_ready,
   output logic [AWIDTH:0]   o_free_cnt,
   output logic              o_almost_empty,
   output logic              o_err
);

   localparam int                DEPTH    = depth_of(AWIDTH);
   localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0]   LOW_CNT  = (AWIDTH+1)'(LOW_WM);
   localparam logic [AWIDTH-1:0] LAST_K   = AWIDTH'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] k, head, tail, rd_data, wr_addr, wr_data;
   logic [AWIDTH:0]   cnt, cnt_nxt;
   logic [NUM_IN-1:0] arb_gnt, gnt_q;
   logic              run, pop, push, wr_en, err_q, ae_q;

   assign run  = (state == ST_RUN);
   assign pop  = run && (cnt != '0) && (|i_req);
   // A full list still accepts a return when a pop frees a slot in the same cycle.
   assign push = run && i_free && ((cnt != FULL_CNT) || pop);

   gsm_rr_arb #(.NUM_IN(NUM_IN)) u_arb (
      .clk (clk),
      .clr (clr),
      .req (i_req),
      .en  (pop),
      .gnt (arb_gnt)
   );

   assign wr_en   = !clr && (run ? push : 1'b1);
   assign wr_addr = run ? tail : k;
   assign wr_data = run ? i_free_addr : k;

   gsm_sdp_ram #(.AW(AWIDTH), .DW(AWIDTH)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (pop),
      .raddr (head),
      .rdata (rd_data)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_INIT: if (k == LAST_K) begin
            state_nxt = ST_RUN;
            cnt_nxt   = FULL_CNT;
         end
         ST_RUN:  cnt_nxt = cnt + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state <= ST_INIT;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         k     <= '0;
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         gnt_q <= '0;
         err_q <= 1'b0;
         ae_q  <= 1'b1;
      end else begin
         cnt   <= cnt_nxt;
         ae_q  <= (cnt_nxt <= LOW_CNT);
         gnt_q <= pop ? arb_gnt : '0;
         if (!run) k    <= k + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push) tail <= tail + 1'b1;
         if (i_free && (!run || ((cnt == FULL_CNT) && !pop))) err_q <= 1'b1;
      end
   end

   assign o_gnt          = gnt_q;
   assign o_gnt_addr     = (|gnt_q) ? rd_data : '0;
   assign o_ready        = run;
   assign o_free_cnt     = cnt;
   assign o_almost_empty = ae_q;
   assign o_err          = err_q;

endmodule

// File: tb/tb_gsm_buf_alloc.sv
// tb/tb_gsm_buf_alloc.sv - self-checking bench for gsm_buf_alloc with a 16-cell list
module tb_gsm_buf_alloc;

   localparam int NI = 4;
   localparam int AW = 4;
   localparam int NV = 23;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic [NI-1:0] i_req = '0;
   logic          i_free = 1'b0;
   logic [AW-1:0] i_free_addr = '0;
   logic [NI-1:0] o_gnt;
   logic [AW-1:0] o_gnt_addr;
   logic          o_ready;
   logic [AW:0]   o_free_cnt;
   logic          o_almost_empty;
   logic          o_err;

   gsm_buf_alloc #(.NUM_IN(NI), .AWIDTH(AW), .LOW_WM(8)) dut (
      .clk            (clk),
      .clr            (clr),
      .i_req          (i_req),
      .o_gnt          (o_gnt),
      .o_gnt_addr     (o_gnt_addr),
      .i_free         (i_free),
      .i_free_addr    (i_free_addr),
      .o_ready        (o_ready),
      .o_free_cnt     (o_free_cnt),
      .o_almost_empty (o_almost_empty),
      .o_err          (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NI-1:0] req;
      logic          free;
      logic [AW-1:0] faddr;
      logic [NI-1:0] egnt;
      logic [AW-1:0] eaddr;
      logic [AW:0]   ecnt;
      logic          eae;
   } vec_t;

   typedef struct {
      logic [NI-1:0] g;
      logic [AW-1:0] a;
   } gexp_t;

   vec_t  vt [NV];
   gexp_t sb [$];
   int    n_vec = 0;
   int    n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_gnt(input logic [NI-1:0] g, input logic [AW-1:0] a);
      gexp_t e;
      e.g = g;
      e.a = a;
      sb.push_back(e);
   endtask

   task automatic check_gnt(input string tag);
      gexp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_gnt"}, 32'(o_gnt), 32'(e.g));
         chk({tag, "_gnt_addr"}, 32'(o_gnt_addr), 32'(e.a));
      end else if (o_gnt != '0) begin
         chk({tag, "_unexpected_gnt"}, 32'(o_gnt), 32'd0);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_gnt"}, 32'(o_gnt), 32'd0);
      chk({tag, "_gnt_addr"}, 32'(o_gnt_addr), 32'd0);
      chk({tag, "_ready"}, 32'(o_ready), 32'd0);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
      chk({tag, "_free_cnt"}, 32'(o_free_cnt), 32'd0);
      chk({tag, "_almost_empty"}, 32'(o_almost_empty), 32'd1);
   endtask

   task automatic wait_ready(input int exp_n);
      int n;
      n = 0;
      while (!o_ready && n < 100) begin
         tick();
         n++;
      end
      chk("init_cycles", 32'(n), 32'(exp_n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Free list starts 0..15 in order, RR pointer 0; cells returned: 3 (at cnt 10), 0, then 5 when empty.
      vt[0]  = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd0,  5'd15, 1'b0};
      vt[1]  = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd1,  5'd14, 1'b0};
      vt[2]  = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd2,  5'd13, 1'b0};
      vt[3]  = '{4'b1111, 1'b0, 4'd0, 4'b0010, 4'd3,  5'd12, 1'b0};
      vt[4]  = '{4'b1111, 1'b0, 4'd0, 4'b0100, 4'd4,  5'd11, 1'b0};
      vt[5]  = '{4'b1111, 1'b0, 4'd0, 4'b1000, 4'd5,  5'd10, 1'b0};
      vt[6]  = '{4'b0100, 1'b1, 4'd3, 4'b0100, 4'd6,  5'd10, 1'b0};
      vt[7]  = '{4'b1001, 1'b0, 4'd0, 4'b1000, 4'd7,  5'd9,  1'b0};
      vt[8]  = '{4'b1001, 1'b0, 4'd0, 4'b0001, 4'd8,  5'd8,  1'b1};
      vt[9]  = '{4'b0000, 1'b1, 4'd0, 4'b0000, 4'd0,  5'd9,  1'b0};
      vt[10] = '{4'b0010, 1'b0, 4'd0, 4'b0010, 4'd9,  5'd8,  1'b1};
      vt[11] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd10, 5'd7,  1'b1};
      vt[12] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd11, 5'd6,  1'b1};
      vt[13] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd12, 5'd5,  1'b1};
      vt[14] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd13, 5'd4,  1'b1};
      vt[15] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd14, 5'd3,  1'b1};
      vt[16] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd15, 5'd2,  1'b1};
      vt[17] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd3,  5'd1,  1'b1};
      vt[18] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd0,  5'd0,  1'b1};
      vt[19] = '{4'b0001, 1'b0, 4'd0, 4'b0000, 4'd0,  5'd0,  1'b1};
      vt[20] = '{4'b0001, 1'b1, 4'd5, 4'b0000, 4'd0,  5'd1,  1'b1};
      vt[21] = '{4'b0001, 1'b0, 4'd0, 4'b0001, 4'd5,  5'd0,  1'b1};
      vt[22] = '{4'b0000, 1'b0, 4'd0, 4'b0000, 4'd0,  5'd0,  1'b1};

      clr = 1'b1;
      tick();
      tick();
      check_reset("reset");

      clr = 1'b0;
      wait_ready(16);
      chk("init_free_cnt", 32'(o_free_cnt), 32'd16);
      chk("init_almost_empty", 32'(o_almost_empty), 32'd0);
      chk("init_err", 32'(o_err), 32'd0);

      for (int i = 0; i < NV; i++) begin
         i_req       = vt[i].req;
         i_free      = vt[i].free;
         i_free_addr = vt[i].faddr;
         if (vt[i].egnt != '0) expect_gnt(vt[i].egnt, vt[i].eaddr);
         tick();
         check_gnt($sformatf("v%0d", i));
         chk($sformatf("v%0d_free_cnt", i), 32'(o_free_cnt), 32'(vt[i].ecnt));
         chk($sformatf("v%0d_almost_empty", i), 32'(o_almost_empty), 32'(vt[i].eae));
         chk($sformatf("v%0d_err", i), 32'(o_err), 32'd0);
      end
      i_req  = '0;
      i_free = 1'b0;

      // Return strobe during INIT is dropped and flagged; flag is sticky.
      clr = 1'b1;
      tick();
      clr         = 1'b0;
      i_free      = 1'b1;
      i_free_addr = 4'd2;
      tick();
      i_free = 1'b0;
      chk("init_free_err", 32'(o_err), 32'd1);
      wait_ready(15);
      chk("init_free_cnt_after", 32'(o_free_cnt), 32'd16);
      chk("init_free_err_sticky", 32'(o_err), 32'd1);

      // Return into a full list with no pop: dropped, flagged, list untouched.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      wait_ready(16);
      i_free      = 1'b1;
      i_free_addr = 4'd7;
      tick();
      i_free = 1'b0;
      chk("ovf_err", 32'(o_err), 32'd1);
      chk("ovf_free_cnt", 32'(o_free_cnt), 32'd16);
      i_req = 4'b0001;
      expect_gnt(4'b0001, 4'd0);
      tick();
      check_gnt("ovf_first");
      i_req = '0;

      // Round-robin from a fresh pointer, then reset in the middle of the burst.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      wait_ready(16);
      i_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         expect_gnt(NI'(1 << i), AW'(i));
         tick();
         check_gnt($sformatf("rr%0d", i));
      end
      clr = 1'b1;
      tick();
      check_reset("midclr");
      tick();
      check_gnt("midclr_hold");
      clr   = 1'b0;
      i_req = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gsm_buf_alloc.md
Name: gsm_buf_alloc

Overview:
- Free-cell allocator and ingress arbiter for one grouped-share-memory bank.
- Holds a free list of the 2^AWIDTH cell addresses.
- Each cycle, grants at most one free write address to one of NUM_IN ingress requesters, chosen round-robin.
- Recycles addresses returned by the bank's buffer-free output; the grant address drives the bank's write address.

Parameters:
- NUM_IN, 4: number of ingress requesters.
- AWIDTH, 9: cell address width; DEPTH = 2^AWIDTH cells.
- LOW_WM, 8: almost-empty threshold, in free cells.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- i_req  in  NUM_IN  level request per ingress; requester drops it the cycle after it sees its grant, or gets a further grant.
- o_gnt  out  NUM_IN  one-hot grant, single-cycle pulse.
- o_gnt_addr  out  AWIDTH  allocated cell address; valid only while |o_gnt.
- i_free  in  1  return-address strobe (from bank buf-free).
- i_free_addr  in  AWIDTH  address being returned.
- o_ready  out  1  initialisation done; allocator running.
- o_free_cnt  out  AWIDTH+1  current number of free cells.
- o_almost_empty  out  1  high when o_free_cnt <= LOW_WM.
- o_err  out  1  sticky: free-list overflow, or free during INIT.

Behaviour:
- Storage: circular free list in a DEPTH x AWIDTH simple dual-port RAM.
  - Synchronous read, 1-cycle latency.
  - Pointers: head (pop), tail (push), both AWIDTH bits with natural wrap.
  - Count: cnt, AWIDTH+1 bits.
- Reset (clr, any cycle, including mid-operation): state=INIT, head=0, tail=0, cnt=0, init counter k=0, RR pointer=0. o_gnt=0, o_ready=0, o_err=0, o_free_cnt=0, o_almost_empty=1, o_gnt_addr=0. In-flight grants are discarded.
- INIT:
  - Each cycle writes mem[k]=k and increments k; k reaches DEPTH-1 after DEPTH cycles.
  - On the cycle writing DEPTH-1, next state=RUN, cnt=DEPTH, tail=0, o_ready=1. INIT lasts exactly DEPTH cycles.
  - i_req is ignored. i_free is dropped and sets o_err.
- RUN, allocation:
  - If cnt!=0 and |i_req: the RR arbiter picks winner w (first requester at or after the RR pointer), reads mem[head], head++, and the RR pointer becomes w+1 mod NUM_IN.
  - Next cycle: o_gnt=onehot(w) and o_gnt_addr=read data. Total latency request->grant is 1 cycle.
  - If cnt==0: no grant, requests stay pending, RR pointer unchanged.
- RUN, free: if i_free, writes mem[tail]=i_free_addr, tail++.
  - If cnt==DEPTH and no pop this cycle: the push is dropped and o_err set.
- Simultaneous pop and push in one cycle: both occur and cnt is unchanged.
  - With cnt==0, the push occurs and no pop; the address is grantable next cycle.
  - A pushed address is readable by a pop one cycle later (no same-cycle bypass).
- cnt update: cnt + push - pop. o_free_cnt=cnt, registered. o_almost_empty is registered from the next-state cnt.
- No double-free detection; upstream guarantees each address is returned once.

Decomposition:
- Shared package: state encoding (INIT, RUN), DEPTH = 1<<AWIDTH, clogb helper for counter widths.
- Sub-module gsm_rr_arb: NUM_IN-way round-robin arbiter.
  - Inputs: req, enable, and a pointer-update on grant.
  - Output: one-hot grant.
- Free-list RAM uses the team's existing inferred simple dual-port RAM.

Test Plan:
- Init (AWIDTH=4): deassert clr -> o_ready rises after exactly 16 cycles; o_free_cnt=16; o_almost_empty=0 (LOW_WM=8).
- Sequential alloc: i_req=0001 held 3 cycles after ready -> o_gnt=0001 on 3 consecutive cycles; o_gnt_addr=0,1,2; o_free_cnt=13.
- Round-robin: i_req=1111 held 4 cycles -> grants 0001,0010,0100,1000; addresses 0..3.
- Exhaust and recycle:
  - Allocate all 16 -> o_free_cnt=0, no further grants with i_req=0001.
  - Then i_free=1, i_free_addr=5 -> grant of address 5 two cycles after the free strobe.
- Simultaneous pop and push at cnt=10: one alloc plus i_free_addr=3 in the same cycle -> o_free_cnt stays 10; 3 is later granted in FIFO order.
- Errors, each checked from a fresh clr:
  - i_free during INIT -> o_err=1.
  - i_free with cnt=16 in RUN and no alloc -> o_err=1, cnt stays 16.
  - clr mid-burst -> all outputs return to reset values next cycle.
